load_align_extend: RTL and testbench



---
 rtl/load_align_extend.sv | 172 +++++++++++++++++
 tb/tb_load_align_extend.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_extend.sv
// Load-data aligner/extender for the MEM/WB boundary: selects the addressed lane,
// sign/zero-extends it, and passes it through an output register plus one-entry skid buffer.
module load_align_extend #(
  parameter int unsigned SIZE_WORD = 32,
  parameter int unsigned SIZE_TAG  = 5,
  parameter int unsigned SIZE_CNT  = 16,
  localparam int unsigned ADDR_W   = $clog2(SIZE_WORD / 8)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIZE_WORD-1:0] mem_rdata,
  input  logic [ADDR_W-1:0]    addr_lo,
  input  logic [1:0]           size,
  input  logic                 is_unsigned,
  input  logic [SIZE_TAG-1:0]  tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE_WORD-1:0] out_data,
  output logic [SIZE_TAG-1:0]  out_tag,
  output logic                 out_err,
  output logic [SIZE_CNT-1:0]  err_count
);

  localparam logic [SIZE_WORD-1:0] ONES    = '1;
  localparam logic [SIZE_CNT-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_e;

  state_e state_q, state_d;

  logic                 in_ready_q, in_ready_d;
  logic [SIZE_WORD-1:0] out_data_q, out_data_d;
  logic [SIZE_TAG-1:0]  out_tag_q, out_tag_d;
  logic                 out_err_q, out_err_d;
  logic [SIZE_WORD-1:0] skid_data_q, skid_data_d;
  logic [SIZE_TAG-1:0]  skid_tag_q, skid_tag_d;
  logic                 skid_err_q, skid_err_d;
  logic [SIZE_CNT-1:0]  err_count_q, err_count_d;

  logic [ADDR_W+2:0]    shamt;
  logic [7:0]           field_w;
  logic [SIZE_WORD-1:0] shifted;
  logic [SIZE_WORD-1:0] hi_mask;
  logic [SIZE_WORD-1:0] msb_sel;
  logic                 field_msb;
  logic [SIZE_WORD-1:0] beat_data;
  logic                 beat_err;
  logic                 accept;
  logic                 drain;

  // Lane extraction and extension. hi_mask covers the bits above the field;
  // a full-width field gives an empty mask, so words pass through untouched.
  always_comb begin
    shamt   = {addr_lo, 3'b000};
    shifted = mem_rdata >> shamt;
    unique case (size)
      2'd0:    field_w = 8'd8;
      2'd1:    field_w = 8'd16;
      2'd2:    field_w = 8'd32;
      default: field_w = 8'(SIZE_WORD);
    endcase
    hi_mask   = ONES << field_w;
    msb_sel   = ~hi_mask & (hi_mask >> 1);
    field_msb = |(shifted & msb_sel);

    unique case (size)
      2'd0:    beat_err = 1'b0;
      2'd1:    beat_err = addr_lo[0];
      2'd2:    beat_err = (addr_lo[1:0] != 2'b00);
      default: beat_err = (SIZE_WORD == 32) || (addr_lo != '0);
    endcase

    if (beat_err) begin
      beat_data = '0;
    end else begin
      beat_data = (shifted & ~hi_mask) | ((field_msb && !is_unsigned) ? hi_mask : '0);
    end
  end

  assign accept = in_valid & in_ready_q;
  assign drain  = (state_q != S_EMPTY) & out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_err_d   = out_err_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    skid_err_d  = skid_err_q;
    err_count_d = err_count_q;

    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          out_data_d = beat_data;
          out_tag_d  = tag_in;
          out_err_d  = beat_err;
          state_d    = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && drain) begin
          out_data_d = beat_data;
          out_tag_d  = tag_in;
          out_err_d  = beat_err;
        end else if (accept) begin
          skid_data_d = beat_data;
          skid_tag_d  = tag_in;
          skid_err_d  = beat_err;
          state_d     = S_FULL;
        end else if (drain) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (drain) begin
          out_data_d = skid_data_q;
          out_tag_d  = skid_tag_q;
          out_err_d  = skid_err_q;
          state_d    = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (accept && beat_err && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + SIZE_CNT'(1);
    end

    // Ready is registered from the next state so out_ready never reaches in_ready.
    in_ready_d = (state_d != S_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      skid_err_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
      skid_err_q  <= skid_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_load_align_extend.sv
// Directed bench for load_align_extend: a 32-bit build and a 64-bit build with a
// 2-bit error counter so saturation is reachable in a few beats.
module tb_load_align_extend;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, out_err, is_unsigned;
  logic [31:0] mem_rdata, out_data;
  logic [1:0]  addr_lo, size;
  logic [4:0]  tag_in, out_tag;
  logic [15:0] err_count;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_err, w_is_unsigned;
  logic [63:0] w_mem_rdata, w_out_data;
  logic [2:0]  w_addr_lo;
  logic [1:0]  w_size;
  logic [4:0]  w_tag_in, w_out_tag;
  logic [1:0]  w_err_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  load_align_extend #(.SIZE_WORD(32), .SIZE_TAG(5), .SIZE_CNT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_rdata(mem_rdata), .addr_lo(addr_lo), .size(size), .is_unsigned(is_unsigned),
    .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err), .err_count(err_count)
  );

  load_align_extend #(.SIZE_WORD(64), .SIZE_TAG(5), .SIZE_CNT(2)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .mem_rdata(w_mem_rdata), .addr_lo(w_addr_lo), .size(w_size), .is_unsigned(w_is_unsigned),
    .tag_in(w_tag_in), .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_tag(w_out_tag), .out_err(w_out_err), .err_count(w_err_count)
  );

  typedef struct {
    logic [31:0] d; logic [1:0] a; logic [1:0] s; logic u; logic [4:0] t;
    logic [31:0] exp; logic err; logic [15:0] cnt;
  } vec32_t;

  typedef struct {
    logic [63:0] d; logic [2:0] a; logic [1:0] s; logic u; logic [4:0] t;
    logic [63:0] exp; logic err; logic [1:0] cnt;
  } vec64_t;

  task automatic drive32(input logic [31:0] d, input logic [1:0] a, input logic [1:0] s,
                         input logic u, input logic [4:0] t);
    mem_rdata = d; addr_lo = a; size = s; is_unsigned = u; tag_in = t; in_valid = 1'b1;
  endtask

  // One beat into an empty (or draining) 32-bit block; returns 1 time unit after the accept edge.
  task automatic send32(input vec32_t v);
    drive32(v.d, v.a, v.s, v.u, v.t);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send64(input vec64_t v);
    w_mem_rdata = v.d; w_addr_lo = v.a; w_size = v.s; w_is_unsigned = v.u; w_tag_in = v.t;
    w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; w_in_valid = 1'b0; out_ready = 1'b1; w_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_vec++; if (out_tag !== 5'd0) begin n_err++; $display("FAIL reset_out_tag: got %0d want 0", out_tag); end
    n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    n_vec++; if (err_count !== 16'h0) begin n_err++; $display("FAIL reset_err_count: got %h want 0", err_count); end
    n_vec++; if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_w64: got valid=%b ready=%b want 0/1", w_out_valid, w_in_ready);
    end
  endtask

  task automatic test_extend;
    vec32_t tbl [7];
    tbl[0] = '{d: 32'h12345680, a: 2'd0, s: 2'd0, u: 1'b0, t: 5'd7, exp: 32'hFFFFFF80, err: 1'b0, cnt: 16'd0};
    tbl[1] = '{d: 32'hBEEF0000, a: 2'd2, s: 2'd1, u: 1'b1, t: 5'd3, exp: 32'h0000BEEF, err: 1'b0, cnt: 16'd0};
    tbl[2] = '{d: 32'hBEEF0000, a: 2'd2, s: 2'd1, u: 1'b0, t: 5'd4, exp: 32'hFFFFBEEF, err: 1'b0, cnt: 16'd0};
    tbl[3] = '{d: 32'hBEEF0000, a: 2'd3, s: 2'd0, u: 1'b0, t: 5'd5, exp: 32'hFFFFFFBE, err: 1'b0, cnt: 16'd0};
    tbl[4] = '{d: 32'h12345680, a: 2'd1, s: 2'd0, u: 1'b1, t: 5'd6, exp: 32'h00000056, err: 1'b0, cnt: 16'd0};
    tbl[5] = '{d: 32'h89ABCDEF, a: 2'd0, s: 2'd2, u: 1'b1, t: 5'd8, exp: 32'h89ABCDEF, err: 1'b0, cnt: 16'd0};
    tbl[6] = '{d: 32'h0000007F, a: 2'd0, s: 2'd0, u: 1'b0, t: 5'd9, exp: 32'h0000007F, err: 1'b0, cnt: 16'd0};
    for (int i = 0; i < 7; i++) begin
      send32(tbl[i]);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL extend%0d_valid: got %b want 1", i, out_valid); end
      n_vec++; if (out_data !== tbl[i].exp) begin n_err++; $display("FAIL extend%0d_data: got %h want %h", i, out_data, tbl[i].exp); end
      n_vec++; if (out_tag !== tbl[i].t) begin n_err++; $display("FAIL extend%0d_tag: got %0d want %0d", i, out_tag, tbl[i].t); end
      n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL extend%0d_err: got %b want 0", i, out_err); end
    end
    n_vec++; if (err_count !== 16'd0) begin n_err++; $display("FAIL extend_err_count: got %0d want 0", err_count); end
  endtask

  task automatic test_errors;
    vec32_t tbl [3];
    tbl[0] = '{d: 32'hBEEF0000, a: 2'd1, s: 2'd1, u: 1'b0, t: 5'd10, exp: 32'h0, err: 1'b1, cnt: 16'd1};
    tbl[1] = '{d: 32'h12345678, a: 2'd0, s: 2'd3, u: 1'b0, t: 5'd11, exp: 32'h0, err: 1'b1, cnt: 16'd2};
    tbl[2] = '{d: 32'hCAFEF00D, a: 2'd2, s: 2'd2, u: 1'b1, t: 5'd12, exp: 32'h0, err: 1'b1, cnt: 16'd3};
    for (int i = 0; i < 3; i++) begin
      send32(tbl[i]);
      n_vec++; if (out_err !== 1'b1) begin n_err++; $display("FAIL error%0d_err: got %b want 1", i, out_err); end
      n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL error%0d_data: got %h want 0", i, out_data); end
      n_vec++; if (out_tag !== tbl[i].t) begin n_err++; $display("FAIL error%0d_tag: got %0d want %0d", i, out_tag, tbl[i].t); end
      n_vec++; if (err_count !== tbl[i].cnt) begin n_err++; $display("FAIL error%0d_count: got %0d want %0d", i, err_count, tbl[i].cnt); end
    end
  endtask

  task automatic test_back_to_back;
    int unsigned next_send = 1;
    int unsigned next_recv = 1;
    logic        sent_now;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 1 && cyc <= 3);
      if (next_send <= 6) drive32(32'h000000A0 | next_send, 2'd0, 2'd0, 1'b0, 5'(next_send));
      else in_valid = 1'b0;
      if (cyc == 1) begin
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_one: got %b want 1", in_ready); end
      end
      if (cyc == 2) begin
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_full: got %b want 0", in_ready); end
      end
      if (cyc >= 2 && cyc <= 4) begin
        n_vec++; if (out_valid !== 1'b1 || out_tag !== 5'd1 || out_data !== 32'hFFFFFFA1) begin
          n_err++; $display("FAIL b2b_stall_hold%0d: got v=%b tag=%0d data=%h want 1/1/ffffffa1", cyc, out_valid, out_tag, out_data);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++; if (out_tag !== 5'(next_recv) || out_data !== (32'hFFFFFFA0 | next_recv)) begin
          n_err++; $display("FAIL b2b_order%0d: got tag=%0d data=%h want tag=%0d data=%h",
                            next_recv, out_tag, out_data, next_recv, 32'hFFFFFFA0 | next_recv);
        end
        next_recv++;
      end
      sent_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (sent_now) next_send++;
      if (next_send > 6 && next_recv > 6) break;
    end
    in_valid = 1'b0;
    n_vec++; if (next_recv != 7) begin n_err++; $display("FAIL b2b_count: got %0d beats want 6 within budget", next_recv - 1); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_full;
    out_ready = 1'b0;
    drive32(32'h00000001, 2'd0, 2'd0, 1'b1, 5'd9);
    @(posedge clk); #1;
    drive32(32'h00000002, 2'd0, 2'd0, 1'b1, 5'd10);
    @(posedge clk); #1;
    n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL rstfull_fill: got ready=%b valid=%b want 0/1", in_ready, out_valid);
    end
    drive32(32'h00000003, 2'd0, 2'd0, 1'b1, 5'd11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstfull_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstfull_ready: got %b want 1", in_ready); end
    n_vec++; if (err_count !== 16'd0) begin n_err++; $display("FAIL rstfull_count: got %0d want 0", err_count); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstfull_ghost%0d: got valid=%b tag=%0d want 0", i, out_valid, out_tag); end
    end
    send32('{d: 32'h000000F0, a: 2'd0, s: 2'd0, u: 1'b1, t: 5'd12, exp: 32'hF0, err: 1'b0, cnt: 16'd0});
    n_vec++; if (out_tag !== 5'd12 || out_data !== 32'h000000F0) begin
      n_err++; $display("FAIL rstfull_next: got tag=%0d data=%h want 12/000000f0", out_tag, out_data);
    end
  endtask

  task automatic test_wide64;
    vec64_t tbl [8];
    tbl[0] = '{d: 64'h80000001_00000000, a: 3'd4, s: 2'd2, u: 1'b0, t: 5'd1, exp: 64'hFFFFFFFF_80000001, err: 1'b0, cnt: 2'd0};
    tbl[1] = '{d: 64'h80000001_00000000, a: 3'd4, s: 2'd2, u: 1'b1, t: 5'd2, exp: 64'h00000000_80000001, err: 1'b0, cnt: 2'd0};
    tbl[2] = '{d: 64'h81234567_89ABCDEF, a: 3'd0, s: 2'd3, u: 1'b0, t: 5'd3, exp: 64'h81234567_89ABCDEF, err: 1'b0, cnt: 2'd0};
    tbl[3] = '{d: 64'h80010000_00000000, a: 3'd6, s: 2'd1, u: 1'b0, t: 5'd4, exp: 64'hFFFFFFFF_FFFF8001, err: 1'b0, cnt: 2'd0};
    tbl[4] = '{d: 64'h81234567_89ABCDEF, a: 3'd4, s: 2'd3, u: 1'b0, t: 5'd5, exp: 64'h0, err: 1'b1, cnt: 2'd1};
    tbl[5] = '{d: 64'h81234567_89ABCDEF, a: 3'd3, s: 2'd1, u: 1'b0, t: 5'd6, exp: 64'h0, err: 1'b1, cnt: 2'd2};
    tbl[6] = '{d: 64'h81234567_89ABCDEF, a: 3'd2, s: 2'd2, u: 1'b0, t: 5'd7, exp: 64'h0, err: 1'b1, cnt: 2'd3};
    tbl[7] = '{d: 64'h81234567_89ABCDEF, a: 3'd1, s: 2'd3, u: 1'b1, t: 5'd8, exp: 64'h0, err: 1'b1, cnt: 2'd3};
    w_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send64(tbl[i]);
      n_vec++; if (w_out_valid !== 1'b1 || w_out_tag !== tbl[i].t) begin
        n_err++; $display("FAIL w64_%0d_beat: got valid=%b tag=%0d want 1/%0d", i, w_out_valid, w_out_tag, tbl[i].t);
      end
      n_vec++; if (w_out_data !== tbl[i].exp) begin n_err++; $display("FAIL w64_%0d_data: got %h want %h", i, w_out_data, tbl[i].exp); end
      n_vec++; if (w_out_err !== tbl[i].err) begin n_err++; $display("FAIL w64_%0d_err: got %b want %b", i, w_out_err, tbl[i].err); end
      n_vec++; if (w_err_count !== tbl[i].cnt) begin n_err++; $display("FAIL w64_%0d_count: got %0d want %0d", i, w_err_count, tbl[i].cnt); end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; mem_rdata = '0; addr_lo = '0; size = '0; is_unsigned = 1'b0; tag_in = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_mem_rdata = '0; w_addr_lo = '0; w_size = '0; w_is_unsigned = 1'b0; w_tag_in = '0;
    test_reset;
    test_extend;
    test_errors;
    test_back_to_back;
    test_reset_full;
    test_wide64;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
